alu_md: RTL and testbench
=========================

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port kill  input  1  abort in-flight operation (pipeline flush).
REQ-005 SHALL have port in_valid  input  1  operands/op presented.
REQ-006 SHALL have port in_ready  output  1  block can accept; high only in IDLE.
REQ-007 SHALL have port op  input  3  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have port rs1  input  XLEN  first operand (multiplicand/dividend).
REQ-009 SHALL have port rs2  input  XLEN  second operand (multiplier/divisor).
REQ-010 SHALL have port out_valid  output  1  result available; high only in DONE.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  XLEN  registered result; stable while out_valid high.

Function
REQ-013 SHALL accept an operation on an edge where in_valid & in_ready & !kill, latching op, rs1, rs2.
REQ-014 SHALL implement states IDLE -> CALC -> FIX -> DONE -> IDLE; special cases go IDLE -> DONE directly.
REQ-015 SHALL iterate exactly XLEN edges in CALC (one partial-product/quotient bit per edge), one edge in FIX (sign correction, hi/lo select), then enter DONE.
REQ-016 SHALL, for an operation accepted at end of cycle N, assert out_valid in cycle N+XLEN+2 (iterative path) or N+1 (special cases).
REQ-017 SHALL produce MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits of signed*signed, signed*unsigned, unsigned*unsigned 2*XLEN product.
REQ-018 SHALL compute divide on magnitudes, quotient sign = sign(rs1)^sign(rs2), remainder sign = sign(rs1) for DIV/REM; unsigned ops skip sign handling.
REQ-019 SHALL, for divisor zero, return quotient all-ones and remainder = rs1 via special-case path.
REQ-020 SHALL, for DIV/REM with rs1 = most-negative and rs2 = -1, return quotient = rs1 and remainder 0 via special-case path.
REQ-021 SHALL hold result and out_valid while out_valid & !out_ready; on out_valid & out_ready edge return to IDLE.
REQ-022 SHALL keep in_ready low in DONE; no accept in the same cycle a result is consumed.
REQ-023 SHALL, on kill in any state, go to IDLE next edge with no out_valid; kill coincident with in_valid drops the operation.
REQ-024 SHALL treat unknown state encodings as IDLE.

Reset
REQ-025 SHALL, when rst_n low at an edge, enter IDLE: in_ready=1, out_valid=0, result=0, internal accumulators/counter=0.
REQ-026 SHALL give rst_n priority over kill and in_valid; reset mid-CALC discards the operation.

Configuration
REQ-027 SHALL, with macro ALU_MD_FAST_MUL_EN defined, compute all MUL* ops with a single-cycle 2*XLEN product, IDLE -> DONE, out_valid in cycle N+1.
REQ-028 SHALL, without ALU_MD_FAST_MUL_EN, compute MUL* iteratively per REQ-015/016; divide is iterative in both builds.

Structure
REQ-029 SHALL place op funct3 encodings, state encodings and XLEN-independent constants in shared package alu_md_pkg.
REQ-030 SHALL isolate the restoring-divide datapath (magnitude quotient/remainder, one bit per edge) in sub-module alu_md_div; sequencing, multiply and sign fixup stay in alu_md.

Verification
REQ-031 SHALL cover: XLEN=32, MULH rs1=0x80000000, rs2=0x80000000 -> result 0x40000000, out_valid in cycle N+34 (iterative build).
REQ-032 SHALL cover: DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-033 SHALL cover: DIVU rs1=0x1234, rs2=0 -> 0xFFFFFFFF and REMU -> 0x1234, both with out_valid in cycle N+1.
REQ-034 SHALL cover: DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REM -> 0, out_valid in cycle N+1.
REQ-035 SHALL cover: out_ready held low 5 cycles after out_valid -> result and out_valid stable, in_ready low; then kill mid-CALC -> IDLE next edge, no out_valid.
REQ-036 SHALL cover: rst_n low during CALC -> next cycle in_ready=1, out_valid=0, result=0; ALU_MD_FAST_MUL_EN build MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE in cycle N+1.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared op encodings, FSM states and operand-signedness helpers for alu_md.
package alu_md_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_rs1_signed(input logic [2:0] op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic op_rs2_signed(input logic [2:0] op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/alu_md_div.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step.
module alu_md_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d, dsor_q, dsor_d;
  logic [XLEN:0]   rem_shift, diff;

  always_comb begin
    quot_d    = quot_q;
    rem_d     = rem_q;
    dsor_d    = dsor_q;
    // quot_q doubles as the dividend shift register; its MSB feeds the partial remainder
    rem_shift = {rem_q, quot_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dsor_q};
    if (start_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      dsor_d = divisor_i;
    end else if (step_i) begin
      if (!diff[XLEN]) begin
        rem_d  = diff[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d  = rem_shift[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      quot_q <= '0;
      rem_q  <= '0;
      dsor_q <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsor_q <= dsor_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/alu_md.sv
// Iterative RV32M multiply/divide unit. Define ALU_MD_FAST_MUL_EN for single-cycle multiply.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              neg_q, neg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_neg, b_neg, div_start, div_step;
  logic [XLEN-1:0]   a_mag, b_mag, div_quot, div_rem, quot_fix, rem_fix, fix_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_fix;

  assign a_neg    = op_rs1_signed(op) & rs1[XLEN-1];
  assign b_neg    = op_rs2_signed(op) & rs2[XLEN-1];
  assign a_mag    = a_neg ? -rs1 : rs1;
  assign b_mag    = b_neg ? -rs2 : rs2;
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_fix = neg_q ? -prod_q : prod_q;
  assign quot_fix = neg_q ? -div_quot : div_quot;
  assign rem_fix  = neg_q ? -div_rem : div_rem;

  always_comb begin
    if (op_is_div(op_q)) fix_res = op_is_rem(op_q) ? rem_fix : quot_fix;
    else                 fix_res = (op_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

`ifdef ALU_MD_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{a_neg}}, rs1} * {{XLEN{b_neg}}, rs2};
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    result_d  = result_q;
    div_start = 1'b0;
    div_step  = 1'b0;
    if (kill) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StCalc: begin
          cnt_d = cnt_q + CntW'(1);
          if (op_is_div(op_q)) div_step = 1'b1;
          else                 prod_d   = {mul_sum, prod_q[XLEN-1:1]};
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_d = StFix;
            cnt_d   = '0;
          end
        end
        StFix: begin
          result_d = fix_res;
          state_d  = StDone;
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: begin
          if (in_valid) begin
            op_d  = op_e'(op);
            cnt_d = '0;
            if (op_is_div(op)) begin
              if (rs2 == '0) begin
                result_d = op_is_rem(op) ? rs1 : '1;
                state_d  = StDone;
              end else if (op_rs1_signed(op) && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1) begin
                result_d = op_is_rem(op) ? '0 : rs1;
                state_d  = StDone;
              end else begin
                div_start = 1'b1;
                neg_d     = op_is_rem(op) ? a_neg : (a_neg ^ b_neg);
                state_d   = StCalc;
              end
            end else begin
`ifdef ALU_MD_FAST_MUL_EN
              result_d = (op == OpMul) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
              state_d  = StDone;
`else
              mcand_d = a_mag;
              prod_d  = {{XLEN{1'b0}}, b_mag};
              neg_d   = a_neg ^ b_neg;
              state_d = StCalc;
`endif
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  alu_md_div #(
    .XLEN(XLEN)
  ) u_div (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (div_start),
    .step_i    (div_step),
    .dividend_i(a_mag),
    .divisor_i (b_mag),
    .quot_o    (div_quot),
    .rem_o     (div_rem)
  );

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: driver queues expected result and due cycle, monitor checks.
module tb_alu_md;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            kill = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            in_ready, out_valid;
  logic [XLEN-1:0] result;

  alu_md #(
    .XLEN(XLEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .kill     (kill),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   n_want = 0;
  int   first_cyc = 0;
  logic vprev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic with RISC-V division corner cases.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb_, ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (f)
      3'd0: p = sa * sb_;
      3'd1: p = (sa * sb_) >> 32;
      3'd2: p = (sa * ub) >> 32;
      3'd3: p = (ua * ub) >> 32;
      3'd4: p = (b == 0) ? 64'hFFFF_FFFF : ((a == 32'h8000_0000 && b == '1) ? ua
              : 64'($signed(sa) / $signed(sb_)));
      3'd5: p = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
      3'd6: p = (b == 0) ? ua : ((a == 32'h8000_0000 && b == '1) ? 64'd0
              : 64'($signed(sa) % $signed(sb_)));
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == '1) return 1;
`ifdef ALU_MD_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return XLEN + 2;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!vprev) first_cyc = cyc;
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", {32'd0, result}, {32'd0, e.res});
          check("out_valid_cycle", 64'(first_cyc), 64'(e.due));
          n_done++;
        end
      end
    end
    vprev = rst_n & out_valid;
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("issue_in_ready", {63'd0, in_ready}, 64'd1);
      return;
    end
    in_valid = 1'b1;
    op       = f;
    rs1      = a;
    rs2      = b;
    sb.push_back('{model(f, a, b), cyc + latency(f, a, b)});
    n_want++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (n_done < n_want && k < 2000) begin
      @(posedge clk);
      k++;
    end
    #1 check("drain", 64'(n_done), 64'(n_want));
    if (n_done != n_want) begin
      sb.delete();
      n_want = n_done;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Directed corner cases
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'h1234, 32'd0);
    issue(3'd7, 32'h1234, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd0, 32'h0001_0003, 32'hFFFF_FFFE);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();

    // Back-pressure: result must hold for 5 stalled cycles
    out_ready = 1'b0;
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    held = model(3'd4, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check("stall_result", {32'd0, result}, {32'd0, held});
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_done();

    // Kill mid-CALC drops the operation
    issue(3'd4, 32'd100, 32'd3);
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_in_ready", {63'd0, in_ready}, 64'd1);
    check("kill_out_valid", {63'd0, out_valid}, 64'd0);
    void'(sb.pop_back());
    n_want--;
    repeat (40) @(posedge clk);

    // Kill coincident with in_valid: nothing accepted
    @(negedge clk);
    in_valid = 1'b1;
    kill     = 1'b1;
    op       = 3'd5;
    rs1      = 32'h55;
    rs2      = 32'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    kill     = 1'b0;
    check("kill_accept_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 check("kill_accept_out_valid", {63'd0, out_valid}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [2:0] f;
      f = 3'($urandom_range(0, 7));
      issue(f, pick(), pick());
    end
    wait_done();

    // Reset in the middle of CALC discards the operation
    issue(3'd5, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_result", {32'd0, result}, 64'd0);
    sb.delete();
    n_want = n_done;
    @(negedge clk) rst_n = 1'b1;
    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
